// File: rtl/pe_pair_sched.sv
// Schedule sequencer for the dual-PE rotation datapath over a 4x4 complex matrix.
// Runs 2*PE_LAT+4 cycles; start is accepted only in IDLE and outputs decode from state/t only.
module pe_pair_sched #(
    parameter int PE_LAT = 4,
    parameter int CNT_W  = $clog2(2*PE_LAT+4)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [1:0] pe0_valid,
    output logic [1:0] pe1_valid,
    output logic [1:0] pe0_scheme,
    output logic [1:0] pe1_scheme,
    output logic       rd_en,
    output logic [1:0] rd_grp,
    output logic       src_fb,
    output logic       op_swap,
    output logic       wb_en,
    output logic [1:0] wb_grp,
    output logic       wb_swap
);

    localparam logic [1:0] COMPLEX_2_REAL = 2'd0;
    localparam logic [1:0] COMPLEX_ROTATE = 2'd1;
    localparam logic [1:0] REAL_NULLIFIED = 2'd2;
    localparam logic [1:0] RELATED_ROTATE = 2'd3;

    localparam logic [CNT_W-1:0] P1_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] P2_T0   = CNT_W'(PE_LAT);
    localparam logic [CNT_W-1:0] P2_LAST = CNT_W'(PE_LAT + 3);
    localparam logic [CNT_W-1:0] WB_T0   = CNT_W'(2*PE_LAT);
    localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(2*PE_LAT + 3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    t <= '0;
                    if (start && !abort) state <= RUN;
                end
                RUN: begin
                    // abort outranks the terminal count so a cancelled run never reports done
                    if (abort) begin
                        state <= IDLE;
                        t     <= '0;
                    end else if (t == T_LAST) begin
                        state <= DONE;
                        t     <= '0;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    t     <= '0;
                end
                default: begin
                    state <= IDLE;
                    t     <= '0;
                end
            endcase
        end
    end

    logic       in_p1, in_p2, in_fw;
    logic [1:0] g1, g2, g3;

    always_comb begin
        in_p1 = (state == RUN) && (t <= P1_LAST);
        in_p2 = (state == RUN) && (t >= P2_T0) && (t <= P2_LAST);
        in_fw = (state == RUN) && (t >= WB_T0);
        g1    = t[1:0];
        g2    = 2'(t - P2_T0);
        g3    = 2'(t - WB_T0);
    end

    always_comb begin
        ready      = (state == IDLE);
        busy       = (state == RUN);
        done       = (state == DONE);
        pe0_valid  = 2'b00;
        pe0_scheme = 2'd0;
        pe1_scheme = 2'd0;
        rd_en      = 1'b0;
        rd_grp     = 2'd0;
        src_fb     = 1'b0;
        op_swap    = 1'b0;
        wb_en      = 1'b0;
        wb_grp     = 2'd0;
        wb_swap    = 1'b0;
        if (in_p1) begin
            pe0_valid  = 2'b11;
            pe0_scheme = g1[0] ? COMPLEX_ROTATE : COMPLEX_2_REAL;
            pe1_scheme = COMPLEX_ROTATE;
            rd_en      = 1'b1;
            rd_grp     = g1;
        end else if (in_p2) begin
            // second pass feeds back pass-1 results while those same results are written back
            pe0_valid  = 2'b11;
            pe0_scheme = g2[0] ? RELATED_ROTATE : REAL_NULLIFIED;
            pe1_scheme = RELATED_ROTATE;
            src_fb     = 1'b1;
            op_swap    = g2[1];
            wb_en      = 1'b1;
            wb_grp     = g2;
        end else if (in_fw) begin
            wb_en   = 1'b1;
            wb_grp  = g3;
            wb_swap = g3[1];
        end
    end

    assign pe1_valid = pe0_valid;

endmodule

// File: tb/tb_pe_pair_sched.sv
// Bench for pe_pair_sched: PE_LAT=4 and PE_LAT=6 instances share stimulus and are checked against a schedule model.
module tb_pe_pair_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic [1:0] v0;
        logic [1:0] v1;
        logic [1:0] s0;
        logic [1:0] s1;
        logic       rd_en;
        logic [1:0] rd_grp;
        logic       src_fb;
        logic       op_swap;
        logic       wb_en;
        logic [1:0] wb_grp;
        logic       wb_swap;
    } obs_t;

    obs_t o4, o6;

    pe_pair_sched #(.PE_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ready(o4.ready), .busy(o4.busy), .done(o4.done),
        .pe0_valid(o4.v0), .pe1_valid(o4.v1),
        .pe0_scheme(o4.s0), .pe1_scheme(o4.s1),
        .rd_en(o4.rd_en), .rd_grp(o4.rd_grp),
        .src_fb(o4.src_fb), .op_swap(o4.op_swap),
        .wb_en(o4.wb_en), .wb_grp(o4.wb_grp), .wb_swap(o4.wb_swap)
    );

    pe_pair_sched #(.PE_LAT(6)) dut6 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ready(o6.ready), .busy(o6.busy), .done(o6.done),
        .pe0_valid(o6.v0), .pe1_valid(o6.v1),
        .pe0_scheme(o6.s0), .pe1_scheme(o6.s1),
        .rd_en(o6.rd_en), .rd_grp(o6.rd_grp),
        .src_fb(o6.src_fb), .op_swap(o6.op_swap),
        .wb_en(o6.wb_en), .wb_grp(o6.wb_grp), .wb_swap(o6.wb_swap)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model position: -1 idle, -2 done cycle, 0..2L+3 = cycle index within the run.
    int m4 = -1;
    int m6 = -1;

    function automatic int step(int lat, int p, logic s, logic a);
        if (p == -1) return (s && !a) ? 0 : -1;
        if (p == -2) return -1;
        if (a) return -1;
        if (p == 2*lat + 3) return -2;
        return p + 1;
    endfunction

    function automatic obs_t expect_at(int lat, int p);
        obs_t e;
        int g;
        e = '0;
        if (p == -1) begin
            e.ready = 1'b1;
        end else if (p == -2) begin
            e.done = 1'b1;
        end else begin
            e.busy = 1'b1;
            if (p < 4) begin
                g = p;
                e.v0 = 2'b11; e.v1 = 2'b11;
                e.s0 = (g % 2 == 0) ? 2'd0 : 2'd1;
                e.s1 = 2'd1;
                e.rd_en = 1'b1;
                e.rd_grp = 2'(g);
            end else if (p >= lat && p < lat + 4) begin
                g = p - lat;
                e.v0 = 2'b11; e.v1 = 2'b11;
                e.s0 = (g % 2 == 0) ? 2'd2 : 2'd3;
                e.s1 = 2'd3;
                e.src_fb = 1'b1;
                e.op_swap = (g >= 2);
                e.wb_en = 1'b1;
                e.wb_grp = 2'(g);
            end else if (p >= 2*lat) begin
                g = p - 2*lat;
                e.wb_en = 1'b1;
                e.wb_grp = 2'(g);
                e.wb_swap = (g >= 2);
            end
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4 = -1;
            m6 = -1;
        end else begin
            m4 = step(4, m4, start, abort);
            m6 = step(6, m6, start, abort);
        end
    end

    always @(negedge clk) begin
        obs_t e4, e6;
        e4 = expect_at(4, m4);
        e6 = expect_at(6, m6);
        n_chk = n_chk + 2;
        if (o4 !== e4) begin
            n_fail++;
            $display("FAIL model_lat4 pos=%0d got=%05h want=%05h at %0t", m4, o4, e4, $time);
        end
        if (o6 !== e6) begin
            n_fail++;
            $display("FAIL model_lat6 pos=%0d got=%05h want=%05h at %0t", m6, o6, e6, $time);
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    int busy4, done4_k, ready4_k, done6_k, dones, seen;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lit("reset_ready", int'(o4.ready), 1);
        lit("reset_busy", int'(o4.busy), 0);

        // Full run on both latencies with literal spot checks.
        busy4 = 0; done4_k = 0; ready4_k = 0; done6_k = 0;
        pulse_start();
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (o4.busy) busy4++;
            if (o4.done && done4_k == 0) done4_k = k;
            if (o6.done && done6_k == 0) done6_k = k;
            if (done4_k != 0 && ready4_k == 0 && o4.ready) ready4_k = k;
            if (k == 1) begin
                lit("t0_s0", int'(o4.s0), 0);
                lit("t0_s1", int'(o4.s1), 1);
                lit("t0_rd_grp", int'(o4.rd_grp), 0);
                lit("t0_rd_en", int'(o4.rd_en), 1);
            end
            if (k == 5) begin
                lit("t4_s0", int'(o4.s0), 2);
                lit("t4_s1", int'(o4.s1), 3);
                lit("t4_src_fb", int'(o4.src_fb), 1);
                lit("t4_wb_grp", int'(o4.wb_grp), 0);
                lit("t4_wb_swap", int'(o4.wb_swap), 0);
                lit("l6_t4_valid", int'(o6.v0), 0);
                lit("l6_t4_wb_en", int'(o6.wb_en), 0);
            end
            if (k == 6) lit("l6_t5_valid", int'(o6.v0), 0);
            if (k == 7) begin
                lit("t6_op_swap", int'(o4.op_swap), 1);
                lit("l6_t6_valid", int'(o6.v0), 3);
                lit("l6_t6_src_fb", int'(o6.src_fb), 1);
            end
            if (k == 11) begin
                lit("t10_wb_grp", int'(o4.wb_grp), 2);
                lit("t10_wb_swap", int'(o4.wb_swap), 1);
                lit("t10_valid", int'(o4.v0), 0);
                lit("l6_t10_wb_en", int'(o6.wb_en), 0);
            end
            if (k == 12) lit("l6_t11_valid", int'(o6.v0), 0);
        end
        lit("busy_cycles_l4", busy4, 12);
        lit("done_k_l4", done4_k, 13);
        lit("ready_k_l4", ready4_k, 14);
        lit("done_k_l6", done6_k, 17);

        // Abort at t=5.
        pulse_start();
        for (int k = 1; k <= 6; k++) @(negedge clk);
        lit("abort_pre_wb", int'(o4.wb_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        lit("abort_ready", int'(o4.ready), 1);
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o4.done || o6.done || o4.wb_en || o6.wb_en) dones++;
        end
        lit("abort_no_done_wb", dones, 0);

        // start and abort together in IDLE.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        lit("start_abort_idle", int'(o4.ready), 1);
        lit("start_abort_busy", int'(o6.busy), 0);

        // start held through RUN and DONE.
        @(negedge clk);
        start = 1'b1;
        seen = 0;
        for (int k = 0; k < 30 && seen == 0; k++) begin
            @(negedge clk);
            if (o4.done) seen = 1;
        end
        lit("held_done_seen", seen, 1);
        @(negedge clk);
        lit("held_idle_ready", int'(o4.ready), 1);
        @(negedge clk);
        lit("held_restart_busy", int'(o4.busy), 1);
        lit("held_restart_rd", int'(o4.rd_en), 1);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);

        // Reset asserted at t=7.
        pulse_start();
        for (int k = 1; k <= 8; k++) @(negedge clk);
        lit("pre_rst_wb_en", int'(o4.wb_en), 1);
        #1 rst = 1'b1;
        #1;
        lit("rst_ready", int'(o4.ready), 1);
        lit("rst_busy", int'(o4.busy), 0);
        lit("rst_wb_en", int'(o4.wb_en), 0);
        lit("rst_valid", int'(o4.v0), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        lit("post_rst_ready", int'(o4.ready), 1);
        pulse_start();
        done4_k = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o4.done && done4_k == 0) done4_k = k;
        end
        lit("post_rst_done_k", done4_k, 13);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_pair_sched.md
Name: pe_pair_sched

Overview:
- Moore-style sequencer for the dual-PE rotation datapath (PE0/PE1, 2x2 complex sub-block each).
- Generates the bidiagonalization schedule for a 4x4 complex channel matrix:
  - per-cycle PE valid and scheme;
  - operand source (matrix store or PE feedback) and operand-order swap;
  - matrix-store read group and write-back group.
- Sits between the top-level receive/send FSM, which pulses start and waits for done, and the PE pair plus the matrix register file.

Parameters:
- PE_LAT, 4, cycles from PE issue to PE output valid; legal range 4..15.
- CNT_W, $clog2(2*PE_LAT+4), width of the internal schedule counter t.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request to run one schedule; accepted only when ready=1
- abort  in  1  synchronous cancel of a running schedule
- ready  out  1  1 in IDLE only
- busy  out  1  1 in RUN
- done  out  1  one-cycle pulse after the last write-back
- pe0_valid  out  2  PE0 input valid (2'b11 on issue, else 2'b00)
- pe1_valid  out  2  PE1 input valid (same as pe0_valid)
- pe0_scheme  out  2  0=COMPLEX_2_REAL, 1=COMPLEX_ROTATE, 2=REAL_NULLIFIED, 3=RELATED_ROTATE
- pe1_scheme  out  2  same encoding as pe0_scheme
- rd_en  out  1  read the matrix store for group rd_grp
- rd_grp  out  2  group index, encoded as {row pair, col pair}
- src_fb  out  1  1: PE inputs from PE outputs (feedback); 0: from the store
- op_swap  out  1  feedback operands exchange x0/y0 with x1/y1
- wb_en  out  1  write PE outputs into the store
- wb_grp  out  2  write-back group
- wb_swap  out  1  PE port 1 writes the even row, port 0 the odd row

Behaviour:
- Reset, or any cycle with rst high:
  - state IDLE, t=0;
  - all outputs 0 except ready=1.
- Groups:
  - g0 = rows 0-1, cols 0-1
  - g1 = rows 0-1, cols 2-3
  - g2 = rows 2-3, cols 0-1
  - g3 = rows 2-3, cols 2-3
  - PE0 takes the even column of the group, PE1 the odd column.
- States: IDLE, RUN, DONE.
- IDLE transitions:
  - start=1 and abort=0 -> RUN with t=0 on the next edge.
  - start and abort both 1 -> stay IDLE; abort wins.
- RUN:
  - t increments by 1 each cycle.
  - t = 2*PE_LAT+3 -> DONE.
  - abort=1 -> IDLE next edge, t cleared, no done pulse, no further writes.
  - start while in RUN is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored (ready=0).
- Outputs are decoded from the registered state and t only; no combinational path from start or abort.
- Issue pass 1, t in 0..3, g = t:
  - valid=2'b11, rd_en=1, rd_grp=g, src_fb=0, op_swap=0.
  - pe0_scheme = COMPLEX_2_REAL for g0/g2, COMPLEX_ROTATE for g1/g3.
  - pe1_scheme = COMPLEX_ROTATE for all groups.
- Issue pass 2, t in PE_LAT..PE_LAT+3, g = t-PE_LAT:
  - valid=2'b11, src_fb=1, op_swap = (g>=2).
  - pe0_scheme = REAL_NULLIFIED for g0/g2, RELATED_ROTATE for g1/g3.
  - pe1_scheme = RELATED_ROTATE for all groups.
  - Same cycle: wb_en=1, wb_grp=g, wb_swap=0 (pass-1 results).
- Final write-back, t in 2*PE_LAT..2*PE_LAT+3, g = t-2*PE_LAT:
  - wb_en=1, wb_grp=g, wb_swap = (g>=2), valid=2'b00.
- Other RUN cycles (only when PE_LAT>4):
  - gap cycles t in 4..PE_LAT-1 and PE_LAT+4..2*PE_LAT-1;
  - all valids, rd_en and wb_en are 0.
- In every cycle where valid=0: scheme=0, src_fb=0, op_swap=0, rd_grp=0. Where wb_en=0: wb_grp=0, wb_swap=0.
- Timing and width:
  - RUN length = 2*PE_LAT+4 cycles; start-to-done = 2*PE_LAT+5 edges.
  - The counter never wraps: the terminal compare forces the exit to DONE.
- Reset asserted mid-RUN: immediate IDLE and all outputs 0, before the next edge.

Test Plan:
- PE_LAT=4; rst pulse, then start high for 1 cycle:
  - ready=1 before start; busy for 12 cycles;
  - done at cycle 13 after start is sampled; ready=1 again at cycle 14.
- PE_LAT=4, check each t:
  - t=0: schemes 0/1, rd_grp=0.
  - t=4: schemes 2/3, src_fb=1, wb_grp=0, wb_swap=0.
  - t=6: op_swap=1.
  - t=10: wb_grp=2, wb_swap=1, valid=2'b00.
- PE_LAT=6:
  - t=4,5 and t=10,11 have no valid and no wb_en;
  - pass 2 starts at t=6; done at 17 cycles after start.
- abort at t=5 (PE_LAT=4):
  - IDLE next cycle, ready=1, no done pulse;
  - wb_en stays 0 from the following cycle onward.
- start and abort together in IDLE -> stays IDLE.
- start held high through RUN and DONE:
  - no restart until IDLE; a new run begins the cycle after returning to IDLE.
- rst asserted at t=7 -> all outputs 0 immediately; after release, ready=1 and a new start runs a full schedule.
